rr_grant_decoder: RTL and testbench
===================================

# rr_grant_decoder

Round-robin grant generator producing a registered one-hot grant vector plus binary grant index from a request vector. It extends plain index-to-one-hot decoding with arbitration, fairness state and a hold/release handshake. It sits in front of shared resources such as a router output port, a memory bank or a shared ALU, where one of NUM_ENTRY requesters must own the resource for multiple cycles.

## Interface
- NUM_ENTRY, 8, number of requesters; any value 2..64, not limited to powers of two
- LOG_NUM_ENTRY, 3, width of the binary index; must equal ceil(log2(NUM_ENTRY))
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- I_Req  in  NUM_ENTRY  request vector; bit i asserts that requester i wants ownership
- I_Rls  in  1  release strobe from the current owner; ignored when no grant is held
- O_Grt  out  NUM_ENTRY  registered one-hot grant; all-zero when idle
- O_GrtNo  out  LOG_NUM_ENTRY  binary index of the owner; valid only while O_Vld=1
- O_Vld  out  1  a grant is currently held

## Operation
- State: `IDLE` / `HOLD` (FSM), owner index `own`, and round-robin pointer `ptr` (next-highest-priority index).
- Winner selection (combinational): scan I_Req starting at ptr, ascending, wrapping from NUM_ENTRY-1 to 0. The first set bit wins. Indices ≥ NUM_ENTRY never exist.
- `IDLE`: if I_Req≠0, go to `HOLD` with own=winner. Otherwise stay.
- `HOLD`: the owner keeps the grant while I_Req[own]=1 and I_Rls=0.
- Release event: I_Rls=1, or I_Req[own] drops to 0 (implicit release).
  - On release, set ptr=(own+1) mod NUM_ENTRY.
  - Re-arbitrate in the same cycle using the updated ptr, with the current owner masked out.
  - If another requester wins, stay in `HOLD` with the new owner; this is a zero-bubble handover.
  - If nobody else is requesting, go to `IDLE`.
  - The released owner can win again only at the next arbitration.
- Requests that arrive during `HOLD` are queued only by being held high. There is no request storage.
- I_Rls in `IDLE` is ignored.
- O_Grt = one-hot(own) when in `HOLD`, else 0. O_Vld = (state==`HOLD`). O_GrtNo = own when in `HOLD`, else 0.
- Invariants:
  - O_Grt has at most one bit set.
  - O_Grt≠0 ⇔ O_Vld.
  - popcount(O_Grt)==O_Vld.
- Fairness: with all requesters continuously requesting and each releasing after k cycles, each owns the resource once per NUM_ENTRY grants.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - State `IDLE`, ptr=0, own=0.
  - O_Grt=0, O_GrtNo=0, O_Vld=0.
- Latency: a request sampled at edge n yields O_Grt valid after edge n (one-cycle registered).
- Release sampled at edge n: the new owner's O_Grt, or all-zero, appears after edge n. The old grant is never visible together with the new one.
- Reset asserted while in `HOLD` drops the grant immediately, without waiting for a clock. After reset deassert, ptr restarts at 0.
- Simultaneous I_Rls and I_Req[own] drop: treated as a single release.
- NUM_ENTRY non-power-of-two: pointer increment wraps explicitly at NUM_ENTRY; it never relies on natural overflow.

## Structure
- Shared package holds:
  - state enum `{IDLE, HOLD}`
  - a `clog2`-based check constant
  - a one-hot encoding function reused by other arbiters
- One natural sub-module, `rr_pick`: purely combinational rotating priority encoder.
  - Inputs: request vector, start pointer, mask.
  - Outputs: winner index and found flag.
- The top level holds the FSM, own/ptr registers and output registers.
- Elaboration-time assertion: LOG_NUM_ENTRY == $clog2(NUM_ENTRY).

## Test plan
- Reset check: hold reset low with I_Req=8'hFF, then release reset → O_Grt=0 until the first edge, then O_Grt=8'h01, O_GrtNo=0.
- Rotation: I_Req=8'hFF held, I_Rls pulsed every 2 cycles → grants 0,1,2,…,7,0 with no idle cycle between owners.
- Implicit release and skip: owner 2 holds, I_Req goes from 8'h24 to 8'h20 → next grant is 5 (8'h20) one cycle later; ptr becomes 3 before the scan.
- Wrap-around, NUM_ENTRY=5, LOG_NUM_ENTRY=3: owner 4 releases with I_Req=5'b00011 → grant to 0 (5'b00001), not to a phantom index 5.
- Sole requester: I_Req=8'h10, I_Rls pulsed → O_Vld falls for one cycle, then 4 is regranted; I_Rls in `IDLE` causes no change.
- Asynchronous reset mid-`HOLD`: assert reset between clock edges → O_Grt=0 and O_Vld=0 immediately; throughout the test, a scoreboard checks popcount(O_Grt)≤1 and O_Grt==one-hot(O_GrtNo) whenever O_Vld=1.

Source files
------------

// File: rtl/rr_grant_decoder_pkg.sv
// Shared types and helpers for the round-robin grant decoder and related arbiters.
// Holds the FSM state encoding, sizing limits and a one-hot encoder.
package rr_grant_decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rr_state_e;

    localparam int RR_MAX_ENTRY = 64;
    localparam int RR_MAX_LOG   = $clog2(RR_MAX_ENTRY);

    // Callers truncate the result to their own requester count.
    function automatic logic [RR_MAX_ENTRY-1:0] rr_onehot(input logic [RR_MAX_LOG-1:0] idx);
        logic [RR_MAX_ENTRY-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_grant_decoder_pick.sv
// Rotating priority encoder: the first unmasked request at or above i_ptr wins,
// wrapping at NUM_ENTRY. Purely combinational.
module rr_pick
    import rr_grant_decoder_pkg::*;
#(
    parameter int NUM_ENTRY     = 8,
    parameter int LOG_NUM_ENTRY = 3
) (
    input  logic [NUM_ENTRY-1:0]     i_req,
    input  logic [LOG_NUM_ENTRY-1:0] i_ptr,
    input  logic [NUM_ENTRY-1:0]     i_mask,
    output logic [LOG_NUM_ENTRY-1:0] o_idx,
    output logic                     o_found
);

    logic [NUM_ENTRY-1:0]   w_live;
    logic [NUM_ENTRY-1:0]   w_rot;
    logic [LOG_NUM_ENTRY:0] w_sum;

    always_comb begin
        w_live  = i_req & ~i_mask;
        // Bit k of w_rot is request (ptr+k) mod NUM_ENTRY; i_ptr is always < NUM_ENTRY.
        w_rot   = NUM_ENTRY'({w_live, w_live} >> i_ptr);
        w_sum   = '0;
        o_found = 1'b0;
        for (int k = NUM_ENTRY - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = {1'b0, i_ptr} + (LOG_NUM_ENTRY + 1)'(k);
            end
        end
        if (w_sum >= (LOG_NUM_ENTRY + 1)'(NUM_ENTRY))
            w_sum = w_sum - (LOG_NUM_ENTRY + 1)'(NUM_ENTRY);
        o_idx = w_sum[LOG_NUM_ENTRY-1:0];
    end

endmodule

// File: rtl/rr_grant_decoder.sv
// Round-robin grant generator with hold/release handshake and zero-bubble handover.
// Grant, index and valid are all registered; reset clears them asynchronously.
module rr_grant_decoder
    import rr_grant_decoder_pkg::*;
#(
    parameter int NUM_ENTRY     = 8,
    parameter int LOG_NUM_ENTRY = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_ENTRY-1:0]     I_Req,
    input  logic                     I_Rls,
    output logic [NUM_ENTRY-1:0]     O_Grt,
    output logic [LOG_NUM_ENTRY-1:0] O_GrtNo,
    output logic                     O_Vld
);

    if (LOG_NUM_ENTRY != $clog2(NUM_ENTRY)) begin : g_bad_log
        $error("LOG_NUM_ENTRY must equal clog2(NUM_ENTRY)");
    end
    if (NUM_ENTRY < 2 || NUM_ENTRY > RR_MAX_ENTRY) begin : g_bad_num
        $error("NUM_ENTRY out of range 2..64");
    end

    rr_state_e                r_state, w_state_nxt;
    logic [LOG_NUM_ENTRY-1:0] r_own, w_own_nxt;
    logic [LOG_NUM_ENTRY-1:0] r_ptr, w_ptr_nxt;
    logic [NUM_ENTRY-1:0]     r_grt;
    logic [LOG_NUM_ENTRY-1:0] r_grtno;
    logic                     r_vld;

    logic [NUM_ENTRY-1:0]     w_own_oh;
    logic [NUM_ENTRY-1:0]     w_grt_nxt;
    logic                     w_own_req;
    logic                     w_rls;
    logic [LOG_NUM_ENTRY-1:0] w_ptr_inc;
    logic [LOG_NUM_ENTRY-1:0] w_pick_ptr;
    logic [NUM_ENTRY-1:0]     w_pick_mask;
    logic [LOG_NUM_ENTRY-1:0] w_win;
    logic                     w_found;

    assign w_own_oh  = NUM_ENTRY'(rr_onehot(RR_MAX_LOG'(r_own)));
    assign w_own_req = |(I_Req & w_own_oh);
    // Explicit wrap so non-power-of-two counts never land on a phantom index.
    assign w_ptr_inc = (r_own == LOG_NUM_ENTRY'(NUM_ENTRY - 1)) ? '0 : r_own + 1'b1;
    // Explicit release and a dropped request collapse into one release event.
    assign w_rls     = (r_state == HOLD) && (I_Rls || !w_own_req);

    // On release the scan restarts past the old owner, which is masked out this cycle.
    assign w_pick_ptr  = w_rls ? w_ptr_inc : r_ptr;
    assign w_pick_mask = w_rls ? w_own_oh  : '0;

    rr_pick #(
        .NUM_ENTRY     (NUM_ENTRY),
        .LOG_NUM_ENTRY (LOG_NUM_ENTRY)
    ) u_pick (
        .i_req   (I_Req),
        .i_ptr   (w_pick_ptr),
        .i_mask  (w_pick_mask),
        .o_idx   (w_win),
        .o_found (w_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_own_nxt   = r_own;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = HOLD;
                    w_own_nxt   = w_win;
                end
            end
            HOLD: begin
                if (w_rls) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (w_found) w_own_nxt   = w_win;
                    else         w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_grt_nxt = (w_state_nxt == HOLD) ? NUM_ENTRY'(rr_onehot(RR_MAX_LOG'(w_own_nxt))) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_own   <= '0;
            r_ptr   <= '0;
            r_grt   <= '0;
            r_grtno <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_own   <= w_own_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grt   <= w_grt_nxt;
            r_grtno <= (w_state_nxt == HOLD) ? w_own_nxt : '0;
            r_vld   <= (w_state_nxt == HOLD);
        end
    end

    assign O_Grt   = r_grt;
    assign O_GrtNo = r_grtno;
    assign O_Vld   = r_vld;

endmodule

// File: tb/tb_rr_grant_decoder.sv
// Scoreboard bench for rr_grant_decoder: an 8-entry instance for the main sequences
// and a 5-entry instance for non-power-of-two wrap behaviour.
module tb_rr_grant_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req8;
    logic       rls8;
    logic [7:0] grt8;
    logic [2:0] no8;
    logic       vld8;
    logic [4:0] req5;
    logic       rls5;
    logic [4:0] grt5;
    logic [2:0] no5;
    logic       vld5;

    always #5 clk = ~clk;

    rr_grant_decoder #(.NUM_ENTRY(8), .LOG_NUM_ENTRY(3)) u_dut8 (
        .clock(clk), .reset(rst_n), .I_Req(req8), .I_Rls(rls8),
        .O_Grt(grt8), .O_GrtNo(no8), .O_Vld(vld8)
    );

    rr_grant_decoder #(.NUM_ENTRY(5), .LOG_NUM_ENTRY(3)) u_dut5 (
        .clock(clk), .reset(rst_n), .I_Req(req5), .I_Rls(rls5),
        .O_Grt(grt5), .O_GrtNo(no5), .O_Vld(vld5)
    );

    typedef struct packed {
        logic [7:0] grt;
        logic [2:0] no;
        logic       vld;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];
    exp_t e8, e5;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge while stimulus is queued, plus invariants.
    always @(posedge clk) begin
        #1;
        if (q8.size() > 0) begin
            e8 = q8.pop_front();
            chk("dut8 {grt,no,vld}", {20'd0, grt8, no8, vld8}, {20'd0, e8});
        end
        if (q5.size() > 0) begin
            e5 = q5.pop_front();
            chk("dut5 {grt,no,vld}", {20'd0, 3'd0, grt5, no5, vld5}, {20'd0, e5});
        end
        chk("inv8 onehot", {24'd0, grt8}, vld8 ? (32'd1 << no8) : 32'd0);
        chk("inv5 onehot", {27'd0, grt5}, vld5 ? (32'd1 << no5) : 32'd0);
    end

    task automatic step8(input logic [7:0] r, input logic l,
                         input logic [7:0] g, input logic [2:0] n, input logic v);
        @(negedge clk);
        req8 = r;
        rls8 = l;
        q8.push_back({g, n, v});
    endtask

    task automatic step5(input logic [4:0] r, input logic l,
                         input logic [4:0] g, input logic [2:0] n, input logic v);
        @(negedge clk);
        req5 = r;
        rls5 = l;
        q5.push_back({3'd0, g, n, v});
    endtask

    initial begin
        rst_n = 1'b0;
        req8  = 8'hFF;
        rls8  = 1'b0;
        req5  = '0;
        rls5  = 1'b0;

        // Reset held with all requests high: nothing granted.
        repeat (3) @(posedge clk);
        #2;
        chk("rst grt8", {24'd0, grt8}, 32'd0);
        chk("rst vld8", {31'd0, vld8}, 32'd0);
        chk("rst no8",  {29'd0, no8},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-rst pre-edge grt8", {24'd0, grt8}, 32'd0);
        q8.push_back({8'h01, 3'd0, 1'b1});

        // Rotation: release every second cycle, handover with no idle gap.
        for (int i = 1; i <= 8; i++) begin
            step8(8'hFF, 1'b0, 8'(1 << (i - 1)), 3'(i - 1), 1'b1);
            step8(8'hFF, 1'b1, 8'(1 << (i % 8)), 3'(i % 8), 1'b1);
        end

        // Implicit release and skip over idle requesters.
        step8(8'h04, 1'b0, 8'h04, 3'd2, 1'b1);
        step8(8'h24, 1'b0, 8'h04, 3'd2, 1'b1);
        step8(8'h20, 1'b0, 8'h20, 3'd5, 1'b1);
        step8(8'h20, 1'b0, 8'h20, 3'd5, 1'b1);

        // Sole requester: one idle cycle after release, then regranted.
        step8(8'h10, 1'b0, 8'h10, 3'd4, 1'b1);
        step8(8'h10, 1'b0, 8'h10, 3'd4, 1'b1);
        step8(8'h10, 1'b1, 8'h00, 3'd0, 1'b0);
        step8(8'h10, 1'b0, 8'h10, 3'd4, 1'b1);
        step8(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        // Release while idle is ignored; pointer stays at 5.
        step8(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
        step8(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
        step8(8'h08, 1'b0, 8'h08, 3'd3, 1'b1);
        // Release strobe together with request drop is a single release.
        step8(8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
        step8(8'h01, 1'b0, 8'h01, 3'd0, 1'b1);

        // Asynchronous reset between edges while holding.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst grt8", {24'd0, grt8}, 32'd0);
        chk("async rst vld8", {31'd0, vld8}, 32'd0);
        req8 = 8'h00;
        rls8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // ptr back at 0: 0 wins over 6.
        step8(8'h41, 1'b0, 8'h01, 3'd0, 1'b1);
        step8(8'h41, 1'b1, 8'h40, 3'd6, 1'b1);
        step8(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

        // Five requesters: pointer wraps from 4 to 0.
        step5(5'b10000, 1'b0, 5'b10000, 3'd4, 1'b1);
        step5(5'b10011, 1'b1, 5'b00001, 3'd0, 1'b1);
        step5(5'b00011, 1'b0, 5'b00001, 3'd0, 1'b1);
        step5(5'b10010, 1'b0, 5'b00010, 3'd1, 1'b1);
        step5(5'b10000, 1'b1, 5'b10000, 3'd4, 1'b1);
        step5(5'b01000, 1'b0, 5'b01000, 3'd3, 1'b1);
        step5(5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(q8.size() + q5.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
